sha1_stream_core: RTL
=====================

// Module: sha1_stream_core
// PURPOSE
//  Multi-block SHA-1 engine: accepts pre-padded 512-bit blocks over a valid/ready handshake and chains
//  H across blocks of one message. It emits the 160-bit digest with a one-cycle done pulse after the last block.
//  Successor to the single-block SHA1 core, adding chaining, backpressure, and a configurable rounds/cycle unroll.
//  Sits between the message padder/packer and the HMAC/KDF wrapper logic.
// PARAMETERS
//  ROUNDS_PER_CYCLE  1   SHA-1 rounds per clock; legal {1,2,4,5,8,10,16,20}; other values fail elaboration.
// PORTS
//  clk        in   1    sole clock, rising edge
//  reset      in   1    synchronous, active-high
//  blk_valid  in   1    blk_data/blk_first/blk_last valid
//  blk_ready  out  1    core can accept a block
//  blk_data   in   512  padded block, word W0 = bits [511:480] (big-endian, matches SHA1 core)
//  blk_first  in   1    block starts a message; chaining H forced to IV
//  blk_last   in   1    block ends the message; digest published on completion
//  hash       out  160  digest, {H0,H1,H2,H3,H4}, H0 in [159:128]
//  done       out  1    one-cycle pulse, hash newly valid
//  busy       out  1    block in flight (state != IDLE)
// BEHAVIOUR
//  - Reset (sync, high): state=IDLE, blk_ready=0 during reset then 1, busy=0, done=0, hash=0, H=IV
//    (67452301 EFCDAB89 98BADCFE 10325476 C3D2E1F0), round counter=0. Reset mid-block aborts; no done.
//  - FSM IDLE -> ROUND -> FINAL -> IDLE. blk_ready = (state==IDLE) && !reset; ready does not depend on blk_valid.
//  - Accept on edge with blk_valid&&blk_ready: latch blk_data into 16x32 W ring and latch blk_last.
//    Load a..e from IV if blk_first, else from H. Go to ROUND.
//  - ROUND: ROUNDS_PER_CYCLE rounds per edge; t advances by R; after 80/R edges go to FINAL.
//  - FINAL (1 edge): H_i <= H_i + a..e (mod 2^32). If latched last: hash <= new H, done=1 next cycle. Go to IDLE.
//  - Latency: done high 80/R+1 edges after accepting edge; block throughput one per 80/R+2 cycles.
//  - Wt: t<16 from ring; t>=16 rotl1(W[t-3]^W[t-8]^W[t-14]^W[t-16]), written back into ring slot t mod 16.
//  - f/K by round t: 0-19 Ch/5A827999, 20-39 Parity/6ED9EBA1, 40-59 Maj/8F1BBCDC, 60-79 Parity/CA62C1D6.
//  - Inputs are ignored outside the accepting edge; hash holds until the next last-block FINAL.
//  - first&&last on one block = single-block message.
//  - Non-first block after a completed message chains from the stored H (= previous digest); no error.
//  - blk_valid in ROUND/FINAL: held off by ready=0; the block is not lost while the producer holds valid.
//  - done and a new acceptance in the same cycle are legal (IDLE after FINAL).
// CONFIGURATION
//  SHA1_IV_LOAD_EN defined: adds ports iv_load (in,1) and iv_data (in,160).
//    iv_load in IDLE writes iv_data into H at the next edge; ignored when busy or on the accepting edge.
//    The next block with blk_first=0 chains from the loaded value (HMAC midstate resume).
//    blk_first=1 still forces the IV constant.
//  Undefined: no such ports; H is only ever IV or chained.
// STRUCTURE
//  sha1_pkg: IV constants, K[4], rotl function, f-select function, round-function typedef for {a,b,c,d,e}.
//  sha1_round sub-module: combinational single round (abcde, Wt, t -> abcde');
//    instantiated ROUNDS_PER_CYCLE times in a chain. W expansion, FSM, and H registers stay in the top.
// TESTING
//  1. R=1, one block "abc" (61626380..18), first=last=1 -> hash a9993e364706816aba3e25717850c26c9cd0d89d, done at edge 81.
//  2. R=1, one block "a..z" (6162..7a80..d0) -> hash 32d10c7b8cf96570ca04ce37f2a19d84240d3a89.
//  3. Two-block "abcdbcde...nopq" (448 bits, len 1c0), first then last, valid held through busy
//     -> 84983e441c3bd26ebaae4aa1f95129e5e54670f1, single done.
//  4. Empty message (80000000..0) for R in {2,5,20}
//     -> da39a3ee5e6b4b0d3255bfef95601890afd80709, done at 80/R+1 edges.
//  5. Reset asserted mid-ROUND, then "abc" -> no done from the aborted block, hash=0 until correct abc digest.
//  6. SHA1_IV_LOAD_EN: iv_load = H after block 1 of test 3, then block 2 with first=0 -> 84983e44...70f1.

Source files
------------

// File: rtl/sha1_pkg.sv
// Shared SHA-1 definitions: chaining IV, round constants, rotate and
// round-function helpers, working-variable struct and FSM state encoding.
package sha1_pkg;

  // Initial chaining value H0..H4.
  localparam logic [31:0] IV0 = 32'h67452301;
  localparam logic [31:0] IV1 = 32'hEFCDAB89;
  localparam logic [31:0] IV2 = 32'h98BADCFE;
  localparam logic [31:0] IV3 = 32'h10325476;
  localparam logic [31:0] IV4 = 32'hC3D2E1F0;
  localparam logic [159:0] IV = {IV0, IV1, IV2, IV3, IV4};

  // Round constants, one per 20-round quarter.
  localparam logic [31:0] K [4] = '{32'h5A827999, 32'h6ED9EBA1,
                                    32'h8F1BBCDC, 32'hCA62C1D6};

  // Working variables {a,b,c,d,e}; a occupies the top word so the packed
  // form lines up with {H0..H4} and the published digest.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
  } abcde_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2
  } state_t;

  // Rotate left by a constant amount (1..31).
  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Round constant for round t.
  function automatic logic [31:0] k_of(input logic [6:0] t);
    if (t < 7'd20)      return K[0];
    else if (t < 7'd40) return K[1];
    else if (t < 7'd60) return K[2];
    else                return K[3];
  endfunction

  // Boolean function for round t: Ch, Parity, Maj, Parity.
  function automatic logic [31:0] f_sel(input logic [6:0] t, input logic [31:0] b,
                                        input logic [31:0] c, input logic [31:0] d);
    if (t < 7'd20)      return (b & c) | (~b & d);
    else if (t < 7'd40) return b ^ c ^ d;
    else if (t < 7'd60) return (b & c) | (b & d) | (c & d);
    else                return b ^ c ^ d;
  endfunction

  // Unroll factors that divide the 80 rounds evenly.
  function automatic bit legal_rounds(input int r);
    return r inside {1, 2, 4, 5, 8, 10, 16, 20};
  endfunction

endpackage

// File: rtl/sha1_stream_core_round.sv
// One combinational SHA-1 round: (abcde, Wt, t) -> abcde'.
// Chained ROUNDS_PER_CYCLE times inside sha1_stream_core.
module sha1_round
  import sha1_pkg::*;
(
  input  abcde_t      cur,
  input  logic [31:0] wt,
  input  logic [6:0]  t,
  output abcde_t      nxt
);

  logic [31:0] temp;

  // Round update: new a from the mixing sum, the rest shift down with b rotated.
  always_comb begin
    temp  = rotl(cur.a, 5) + f_sel(t, cur.b, cur.c, cur.d) + cur.e + k_of(t) + wt;
    nxt.a = temp;
    nxt.b = cur.a;
    nxt.c = rotl(cur.b, 30);
    nxt.d = cur.c;
    nxt.e = cur.d;
  end

endmodule

// File: rtl/sha1_stream_core.sv
// Multi-block SHA-1 engine with H chaining across blocks of one message and
// a configurable number of rounds per clock.
// Optional feature: define SHA1_IV_LOAD_EN to add iv_load/iv_data ports that
// overwrite the chaining value H while idle (midstate resume).
module sha1_stream_core
  import sha1_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  input  logic         blk_last,
`ifdef SHA1_IV_LOAD_EN
  input  logic         iv_load,
  input  logic [159:0] iv_data,
`endif
  output logic [159:0] hash,
  output logic         done,
  output logic         busy
);

  localparam int          R      = ROUNDS_PER_CYCLE;
  localparam logic [6:0]  T_STEP = 7'(R);
  localparam logic [6:0]  T_LAST = 7'(80 - R);

  if (!legal_rounds(R)) begin : g_bad_rounds
    $error("sha1_stream_core: ROUNDS_PER_CYCLE=%0d must be one of 1,2,4,5,8,10,16,20", R);
  end

  state_t      state, state_nxt;
  logic [6:0]  t_cnt;
  logic        last_q;
  logic [31:0] ring     [16];
  logic [31:0] ring_nxt [16];
  logic [31:0] wt       [R];
  logic [6:0]  t_i;
  abcde_t      work;
  abcde_t      h;
  abcde_t      h_sum;
  abcde_t      round_out;
  logic        accept;

  // Ready only when idle and not held in reset; independent of blk_valid.
  assign blk_ready = (state == S_IDLE) && !reset;
  assign busy      = (state != S_IDLE);
  assign accept    = blk_valid && blk_ready;

  // Next-state logic for IDLE -> ROUND -> FINAL -> IDLE.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (accept) state_nxt = S_ROUND;
      S_ROUND: if (t_cnt == T_LAST) state_nxt = S_FINAL;
      S_FINAL: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register; reset aborts any block in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Message schedule for this cycle's R rounds. Words produced early in the
  // cycle are written back into the local ring copy so later rounds of the
  // same cycle see them (needed once R exceeds 3).
  always_comb begin
    ring_nxt = ring;
    wt       = '{default: '0};
    t_i      = '0;
    for (int i = 0; i < R; i++) begin
      t_i = t_cnt + 7'(i);
      if (t_i < 7'd16) begin
        wt[i] = ring_nxt[t_i[3:0]];
      end else begin
        // Slots t-3, t-8, t-14 (= t+2) and t-16 (= t) modulo 16.
        wt[i] = rotl(ring_nxt[t_i[3:0] - 4'd3] ^ ring_nxt[t_i[3:0] - 4'd8] ^
                     ring_nxt[t_i[3:0] + 4'd2] ^ ring_nxt[t_i[3:0]], 1);
        ring_nxt[t_i[3:0]] = wt[i];
      end
    end
  end

  // Unrolled round chain: stage g consumes stage g-1's output.
  for (genvar g = 0; g < R; g++) begin : g_rnd
    abcde_t cur;
    abcde_t nxt;
    if (g == 0) begin : g_head
      assign cur = work;
    end else begin : g_link
      assign cur = g_rnd[g-1].nxt;
    end
    sha1_round u_round (
      .cur (cur),
      .wt  (wt[g]),
      .t   (t_cnt + 7'(g)),
      .nxt (nxt)
    );
  end
  assign round_out = g_rnd[R-1].nxt;

  // Round counter: cleared by reset and on acceptance, steps by R in ROUND.
  always_ff @(posedge clk) begin
    if (reset)                  t_cnt <= '0;
    else if (accept)            t_cnt <= '0;
    else if (state == S_ROUND)  t_cnt <= t_cnt + T_STEP;
  end

  // Block datapath: latch the block on acceptance, then advance a..e and the ring.
  always_ff @(posedge clk) begin
    // NOTE: W ring, working variables and last flag carry no reset; they are
    // always loaded on acceptance before anything reads them.
    if (accept) begin
      last_q <= blk_last;
      for (int i = 0; i < 16; i++) ring[i] <= blk_data[511 - 32*i -: 32];
      work   <= blk_first ? abcde_t'(IV) : h;
    end else if (state == S_ROUND) begin
      ring <= ring_nxt;
      work <= round_out;
    end
  end

  // Feed-forward addition of the block result into the chaining value.
  always_comb begin
    h_sum.a = h.a + work.a;
    h_sum.b = h.b + work.b;
    h_sum.c = h.c + work.c;
    h_sum.d = h.d + work.d;
    h_sum.e = h.e + work.e;
  end

  // Chaining value, published digest and done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      h    <= IV;
      hash <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == S_FINAL) begin
        h <= h_sum;
        if (last_q) begin
          hash <= h_sum;
          done <= 1'b1;
        end
      end else if (accept && blk_first) begin
        // A new message restarts the chain from the IV constant.
        h <= IV;
      end
`ifdef SHA1_IV_LOAD_EN
      else if ((state == S_IDLE) && iv_load && !accept) begin
        h <= iv_data;
      end
`endif
    end
  end

endmodule
